// File: rtl/zynq_ep_credit_gate.sv
// Credit gate between host request stream and manycore endpoint: one-entry
// zero-bubble output buffer, outstanding-credit accounting and a drain fence.
module zynq_ep_credit_gate #(
  parameter int pkt_width_p   = 32,
  parameter int max_credits_p = 32,
  localparam int cw           = $clog2(max_credits_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   host_req_v_i,
  input  logic [pkt_width_p-1:0] host_req_data_i,
  output logic                   host_req_ready_o,
  output logic                   ep_req_v_o,
  output logic [pkt_width_p-1:0] ep_req_data_o,
  input  logic                   ep_req_ready_i,
  input  logic                   ep_credit_return_i,
  input  logic                   fence_i,
  output logic                   fence_done_o,
  output logic [cw-1:0]          credits_used_o,
  output logic                   underflow_err_o
);

  // state | meaning
  // RUN   | accepting host requests while credits remain
  // FENCE | host blocked; waiting for buffer empty and all credits returned
  typedef enum logic [0:0] {RUN, FENCE} state_t;

  localparam logic [cw-1:0] max_cr = cw'(max_credits_p);

  state_t                 state_r, state_n;
  logic                   full_r;
  logic [pkt_width_p-1:0] data_r;
  logic [cw-1:0]          credits_r;
  logic                   underflow_r;
  logic                   host_acc, ep_acc;

  assign ep_acc = full_r & ep_req_ready_i;
  assign host_acc = host_req_v_i & host_req_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= RUN;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n          = state_r;
    host_req_ready_o = 1'b0;
    fence_done_o     = 1'b0;
    case (state_r)
      RUN: begin
        host_req_ready_o = (credits_r < max_cr) && (!full_r || ep_acc);
        if (fence_i) state_n = FENCE;
      end
      FENCE: begin
        if (!full_r && credits_r == '0) begin
          fence_done_o = 1'b1;
          state_n      = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       full_r <= 1'b0;
    else if (host_acc) full_r <= 1'b1;
    else if (ep_acc)   full_r <= 1'b0;
  end

  // Payload needs no reset: it is only observed while the full bit is set.
  always_ff @(posedge clk_i) begin
    if (host_acc) data_r <= host_req_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r   <= '0;
      underflow_r <= 1'b0;
    end else if (host_acc && !ep_credit_return_i) begin
      credits_r <= credits_r + cw'(1);
    end else if (!host_acc && ep_credit_return_i) begin
      if (credits_r == '0) underflow_r <= 1'b1;
      else                 credits_r   <= credits_r - cw'(1);
    end
  end

  assign ep_req_v_o      = full_r;
  assign ep_req_data_o   = data_r;
  assign credits_used_o  = credits_r;
  assign underflow_err_o = underflow_r;

endmodule

// File: tb/tb_zynq_ep_credit_gate.sv
// Directed bench for zynq_ep_credit_gate: streaming, simultaneous consume and
// return, backpressure, fence, underflow and asynchronous mid-run reset.
module tb_zynq_ep_credit_gate;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        host_req_v_i;
  logic [31:0] host_req_data_i;
  logic        host_req_ready_o;
  logic        ep_req_v_o;
  logic [31:0] ep_req_data_o;
  logic        ep_req_ready_i;
  logic        ep_credit_return_i;
  logic        fence_i;
  logic        fence_done_o;
  logic [5:0]  credits_used_o;
  logic        underflow_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  zynq_ep_credit_gate #(.pkt_width_p(32), .max_credits_p(32)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .host_req_v_i       (host_req_v_i),
    .host_req_data_i    (host_req_data_i),
    .host_req_ready_o   (host_req_ready_o),
    .ep_req_v_o         (ep_req_v_o),
    .ep_req_data_o      (ep_req_data_o),
    .ep_req_ready_i     (ep_req_ready_i),
    .ep_credit_return_i (ep_credit_return_i),
    .fence_i            (fence_i),
    .fence_done_o       (fence_done_o),
    .credits_used_o     (credits_used_o),
    .underflow_err_o    (underflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i            = 1'b1;
    host_req_v_i       = 1'b0;
    host_req_data_i    = '0;
    ep_req_ready_i     = 1'b1;
    ep_credit_return_i = 1'b0;
    fence_i            = 1'b0;
    tick();
    tick();
    chk_eq("rst_ep_v", ep_req_v_o, 0);
    chk_eq("rst_credits", credits_used_o, 0);
    chk_eq("rst_underflow", underflow_err_o, 0);
    chk_eq("rst_fence_done", fence_done_o, 0);
    reset_i = 1'b0;

    // Streaming: 32 back-to-back accepts fill the credit pool.
    host_req_v_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      host_req_data_i = 32'd100 + 32'(i);
      #1;
      chk_eq("stream_ready", host_req_ready_o, 1);
      tick();
      chk_eq("stream_credits", credits_used_o, 32'(i + 1));
      chk_eq("stream_data", ep_req_data_o, 32'd100 + 32'(i));
    end
    host_req_data_i = 32'd132;
    #1;
    chk_eq("stream_ready_33", host_req_ready_o, 0);
    tick();
    chk_eq("stream_drained", ep_req_v_o, 0);
    chk_eq("stream_hold32", credits_used_o, 32);

    // Return at the ceiling, then a single accept restores it.
    ep_credit_return_i = 1'b1;
    #1;
    chk_eq("full_ready_ret", host_req_ready_o, 0);
    tick();
    chk_eq("ret_to_31", credits_used_o, 31);
    ep_credit_return_i = 1'b0;
    host_req_data_i = 32'd200;
    #1;
    chk_eq("ready_at_31", host_req_ready_o, 1);
    tick();
    chk_eq("back_to_32", credits_used_o, 32);
    chk_eq("data_200", ep_req_data_o, 200);
    host_req_v_i = 1'b0;
    ep_credit_return_i = 1'b1;
    for (int i = 0; i < 22; i++) tick();
    chk_eq("down_to_10", credits_used_o, 10);
    host_req_v_i = 1'b1;
    host_req_data_i = 32'd201;
    #1;
    chk_eq("simul_ready", host_req_ready_o, 1);
    tick();
    chk_eq("simul_hold10", credits_used_o, 10);

    // Backpressure: buffer holds 201 while the endpoint stalls.
    ep_credit_return_i = 1'b0;
    ep_req_ready_i = 1'b0;
    host_req_data_i = 32'd300;
    #1;
    chk_eq("bp_ready", host_req_ready_o, 0);
    chk_eq("bp_v", ep_req_v_o, 1);
    tick();
    chk_eq("bp_data_a", ep_req_data_o, 201);
    tick();
    chk_eq("bp_data_b", ep_req_data_o, 201);
    chk_eq("bp_credits", credits_used_o, 10);
    ep_req_ready_i = 1'b1;
    #1;
    chk_eq("bp_release_ready", host_req_ready_o, 1);
    tick();
    chk_eq("handoff_v", ep_req_v_o, 1);
    chk_eq("handoff_data", ep_req_data_o, 300);
    chk_eq("handoff_credits", credits_used_o, 11);
    host_req_v_i = 1'b0;
    tick();
    chk_eq("drain_v", ep_req_v_o, 0);

    // Fence with 5 credits outstanding.
    ep_credit_return_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_eq("pre_fence_5", credits_used_o, 5);
    ep_credit_return_i = 1'b0;
    fence_i = 1'b1;
    #1;
    tick();
    fence_i = 1'b0;
    host_req_v_i = 1'b1;
    host_req_data_i = 32'd400;
    #1;
    chk_eq("fence_ready", host_req_ready_o, 0);
    chk_eq("fence_done_early", fence_done_o, 0);
    for (int i = 0; i < 5; i++) begin
      ep_credit_return_i = 1'b1;
      #1;
      chk_eq("fence_wait_done", fence_done_o, 0);
      chk_eq("fence_wait_ready", host_req_ready_o, 0);
      tick();
    end
    ep_credit_return_i = 1'b0;
    #1;
    chk_eq("fence_cnt0", credits_used_o, 0);
    chk_eq("fence_done_pulse", fence_done_o, 1);
    chk_eq("fence_done_ready", host_req_ready_o, 0);
    tick();
    chk_eq("fence_done_clear", fence_done_o, 0);
    chk_eq("fence_resume_ready", host_req_ready_o, 1);
    tick();
    chk_eq("resume_credits", credits_used_o, 1);
    chk_eq("resume_data", ep_req_data_o, 400);

    // Fence with nothing outstanding completes one cycle after the request.
    host_req_v_i = 1'b0;
    ep_credit_return_i = 1'b1;
    tick();
    ep_credit_return_i = 1'b0;
    chk_eq("idle_credits", credits_used_o, 0);
    chk_eq("idle_empty", ep_req_v_o, 0);
    fence_i = 1'b1;
    #1;
    chk_eq("idle_no_done_yet", fence_done_o, 0);
    tick();
    fence_i = 1'b0;
    #1;
    chk_eq("idle_fence_done", fence_done_o, 1);
    tick();
    chk_eq("idle_fence_clear", fence_done_o, 0);

    // Underflow is sticky and the count does not wrap.
    chk_eq("uf_pre", underflow_err_o, 0);
    ep_credit_return_i = 1'b1;
    tick();
    ep_credit_return_i = 1'b0;
    chk_eq("uf_cnt0", credits_used_o, 0);
    chk_eq("uf_set", underflow_err_o, 1);
    tick();
    tick();
    chk_eq("uf_sticky", underflow_err_o, 1);

    // Asynchronous reset with a full buffer and 7 credits outstanding.
    host_req_v_i = 1'b1;
    ep_req_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      host_req_data_i = 32'd500 + 32'(i);
      tick();
    end
    host_req_v_i = 1'b0;
    ep_req_ready_i = 1'b0;
    #1;
    chk_eq("prerst_v", ep_req_v_o, 1);
    chk_eq("prerst_credits", credits_used_o, 7);
    #2;
    reset_i = 1'b1;
    #1;
    chk_eq("async_rst_v", ep_req_v_o, 0);
    chk_eq("async_rst_credits", credits_used_o, 0);
    chk_eq("async_rst_uf", underflow_err_o, 0);
    #2;
    reset_i = 1'b0;
    host_req_v_i = 1'b1;
    ep_req_ready_i = 1'b1;
    host_req_data_i = 32'd600;
    #1;
    chk_eq("postrst_ready", host_req_ready_o, 1);
    tick();
    chk_eq("postrst_credits", credits_used_o, 1);
    chk_eq("postrst_data", ep_req_data_o, 600);
    host_req_v_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zynq_ep_credit_gate.md
ZYNQ_EP_CREDIT_GATE -- requirements
Module: zynq_ep_credit_gate

Interface
REQ-001 The block SHALL have parameter pkt_width_p, default 32: the width of the host request packet in bits.
REQ-002 The block SHALL have parameter max_credits_p, default 32: the maximum number of outstanding endpoint requests.
REQ-003 The block SHALL define derived width cw = clog2(max_credits_p+1), which is 6 at the default.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port host_req_v_i, input, 1 bit: host request valid.
REQ-007 The block SHALL have port host_req_data_i, input, pkt_width_p bits: host request packet.
REQ-008 The block SHALL have port host_req_ready_o, output, 1 bit: the gate accepts the host request.
REQ-009 The block SHALL have port ep_req_v_o, output, 1 bit: request valid towards the manycore endpoint.
REQ-010 The block SHALL have port ep_req_data_o, output, pkt_width_p bits: buffered packet.
REQ-011 The block SHALL have port ep_req_ready_i, input, 1 bit: the endpoint accepts the request.
REQ-012 The block SHALL have port ep_credit_return_i, input, 1 bit: one returned credit per cycle asserted.
REQ-013 The block SHALL have port fence_i, input, 1 bit: fence request pulse.
REQ-014 The block SHALL have port fence_done_o, output, 1 bit: one-cycle pulse when the fence completes.
REQ-015 The block SHALL have port credits_used_o, output, cw bits: outstanding credit count.
REQ-016 The block SHALL have port underflow_err_o, output, 1 bit: sticky credit-underflow flag.

Function
REQ-017 The block SHALL hold a one-entry output buffer (full bit plus data register); ep_req_v_o SHALL equal the full bit, and ep_req_data_o SHALL equal the data register.
REQ-018 The host handshake SHALL complete (host_acc) when host_req_v_i and host_req_ready_o are both high; the endpoint handshake SHALL complete (ep_acc) when ep_req_v_o and ep_req_ready_i are both high.
REQ-019 host_req_ready_o SHALL be high exactly when state==RUN, credits_used < max_credits_p, and (buffer empty or ep_acc); the ready SHALL depend combinationally on ep_req_ready_i.
REQ-020 On host_acc, the buffer SHALL load host_req_data_i and be full on the next cycle; on ep_acc without host_acc, the buffer SHALL become empty; on ep_acc with host_acc, the buffer SHALL stay full with the new data (zero-bubble).
REQ-021 One credit SHALL be consumed on each host_acc, so the count includes the buffered packet.
REQ-022 One credit SHALL be released on each cycle ep_credit_return_i is high.
REQ-023 If a consume and a release occur in the same cycle, credits_used_o SHALL be unchanged.
REQ-024 credits_used_o SHALL never exceed max_credits_p (guaranteed by REQ-019) and SHALL never wrap.
REQ-025 A credit return while credits_used_o==0 with no consume in the same cycle SHALL leave the count at 0 and set underflow_err_o, which stays set until reset.
REQ-026 The FSM SHALL have two states, RUN and FENCE.
REQ-027 In RUN, a cycle with fence_i high SHALL move the FSM to FENCE on the next cycle; a host_acc in that same cycle SHALL still complete.
REQ-028 In FENCE, host_req_ready_o SHALL be 0, and fence_i SHALL be ignored.
REQ-029 In FENCE, the buffer SHALL continue draining and credits SHALL continue returning.
REQ-030 FENCE SHALL exit to RUN when the buffer is empty and credits_used_o==0 (registered values), asserting fence_done_o for exactly that one cycle.
REQ-031 A fence with nothing outstanding SHALL pulse fence_done_o on the cycle after fence_i.
REQ-032 ep_req_data_o SHALL be don't-care while ep_req_v_o==0; the buffer SHALL hold data stable while ep_req_v_o==1 and ep_req_ready_i==0.

Reset
REQ-033 While reset_i is high, and immediately on its assertion (asynchronously), the block SHALL set: state=RUN, buffer empty, credits_used_o=0, underflow_err_o=0, fence_done_o=0, ep_req_v_o=0.
REQ-034 A reset asserted mid-operation SHALL discard the buffered packet and all credit state; the first accept SHALL be possible on the first clock edge after reset_i falls.

Verification
REQ-035 Scenario, streaming: ep_req_ready_i=1, no credit returns, host_req_v_i held high -> 32 consecutive accepts one per cycle, credits_used_o reaches 32, and host_req_ready_o drops to 0 on the 33rd cycle.
REQ-036 Scenario, simultaneous events: at credits_used_o=32, ep_credit_return_i=1 for one cycle -> count goes to 31, then one accept restores 32; consume and return in the same cycle at count 10 -> count stays 10.
REQ-037 Scenario, backpressure: ep_req_ready_i=0 with the buffer full -> host_req_ready_o=0 and ep_req_data_o stable; raise ep_req_ready_i together with host_req_v_i -> handoff occurs with no bubble cycle.
REQ-038 Scenario, fence: with 5 credits outstanding, pulse fence_i -> host_req_ready_o=0; return 5 credits -> fence_done_o is high for exactly 1 cycle after the count reaches 0, then accepts resume.
REQ-039 Scenario, underflow: ep_credit_return_i=1 at count 0 -> count stays 0, underflow_err_o=1 and stays 1 until reset.
REQ-040 Scenario, reset mid-operation: assert reset_i while the buffer is full and count=7 -> ep_req_v_o=0 and count=0 immediately, without waiting for a clock edge.
